// File: rtl/rv_core_pkg.sv
// Shared core definitions: default widths, the hardwired-zero register index
// and the register address type.
package rv_core_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned REG_ZERO      = 0;

    typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register.
// An issue marks its destination busy, a writeback clears it, and a flush clears everything.
module rf_scoreboard
    import rv_core_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         issue_valid,
    input  logic [$clog2(NREGS)-1:0]     issue_rd,
    input  logic                         wa_en,
    input  logic [$clog2(NREGS)-1:0]     wa_addr,
    input  logic                         wb_en,
    input  logic [$clog2(NREGS)-1:0]     wb_addr,
    input  logic                         flush,
    input  logic [$clog2(NREGS)-1:0]     rs1_addr,
    input  logic [$clog2(NREGS)-1:0]     rs2_addr,
    output logic                         rs1_busy,
    output logic                         rs2_busy
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wa_live;
    logic             wb_live;

    assign wa_live = wa_en && (wa_addr != AW'(REG_ZERO));
    assign wb_live = wb_en && (wb_addr != AW'(REG_ZERO));

    // Next busy vector: writes clear first so a same-cycle issue to the
    // same register overrides them; flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (wa_live) busy_d[wa_addr] = 1'b0;
        if (wb_live) busy_d[wb_addr] = 1'b0;
        if (flush) begin
            busy_d = '0;
        end else if (issue_valid && (issue_rd != AW'(REG_ZERO))) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    // Busy state register with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    // Busy lookups: a producer completing this cycle no longer blocks the consumer.
    always_comb begin
        rs1_busy = busy_q[rs1_addr]
                   && !(wa_live && (wa_addr == rs1_addr))
                   && !(wb_live && (wb_addr == rs1_addr))
                   && (rs1_addr != AW'(REG_ZERO));
        rs2_busy = busy_q[rs2_addr]
                   && !(wa_live && (wa_addr == rs2_addr))
                   && !(wb_live && (wb_addr == rs2_addr))
                   && (rs2_addr != AW'(REG_ZERO));
    end

endmodule

// File: rtl/rv_regfile_sb.sv
// RV32I integer register file: two read ports, two write ports (A = ALU,
// B = load return, B wins on collision), optional write-to-read bypass and
// a built-in RAW scoreboard.
module rv_regfile_sb
    import rv_core_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [$clog2(NREGS)-1:0]     rs1_addr,
    input  logic [$clog2(NREGS)-1:0]     rs2_addr,
    output logic [XLEN-1:0]              rd1_data,
    output logic                         rs1_busy,
    output logic [XLEN-1:0]              rd2_data,
    output logic                         rs2_busy,
    input  logic                         issue_valid,
    input  logic [$clog2(NREGS)-1:0]     issue_rd,
    input  logic                         wa_en,
    input  logic [$clog2(NREGS)-1:0]     wa_addr,
    input  logic [XLEN-1:0]              wa_data,
    input  logic                         wb_en,
    input  logic [$clog2(NREGS)-1:0]     wb_addr,
    input  logic [XLEN-1:0]              wb_data,
    input  logic                         flush
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [1:0]      rst_sync;
    logic            rst_n;
    logic [XLEN-1:0] regs [NREGS];
    logic            wa_live;
    logic            wb_live;

    // Reset synchroniser: assertion is immediate, release follows two clock edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n   = rst_sync[1];
    assign wa_live = rst_n && wa_en && (wa_addr != AW'(REG_ZERO));
    assign wb_live = rst_n && wb_en && (wb_addr != AW'(REG_ZERO));

    // Register storage; port B is written last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wa_live) regs[wa_addr] <= wa_data;
            if (wb_live) regs[wb_addr] <= wb_data;
        end
    end

    // Read muxes with optional same-cycle forwarding (port B before port A).
    always_comb begin
        rd1_data = (rs1_addr == AW'(REG_ZERO)) ? '0 : regs[rs1_addr];
        rd2_data = (rs2_addr == AW'(REG_ZERO)) ? '0 : regs[rs2_addr];
        if (BYPASS) begin
            if (wb_live && (wb_addr == rs1_addr))      rd1_data = wb_data;
            else if (wa_live && (wa_addr == rs1_addr)) rd1_data = wa_data;
            if (wb_live && (wb_addr == rs2_addr))      rd2_data = wb_data;
            else if (wa_live && (wa_addr == rs2_addr)) rd2_data = wa_data;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .resetn      (rst_n),
        .issue_valid (issue_valid && rst_n),
        .issue_rd    (issue_rd),
        .wa_en       (wa_en && rst_n),
        .wa_addr     (wa_addr),
        .wb_en       (wb_en && rst_n),
        .wb_addr     (wb_addr),
        .flush       (flush),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Directed bench for rv_regfile_sb: one instance with bypass, one without,
// both driven by the same stimulus.
module tb_rv_regfile_sb;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wa_addr, wb_addr;
    logic [31:0] wa_data, wb_data;
    logic        issue_valid, wa_en, wb_en, flush;

    logic [31:0] rd1_byp, rd2_byp, rd1_nb, rd2_nb;
    logic        b1_byp, b2_byp, b1_nb, b2_nb;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    rv_regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1_data(rd1_byp), .rs1_busy(b1_byp),
        .rd2_data(rd2_byp), .rs2_busy(b2_byp),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush)
    );

    rv_regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .resetn(resetn),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1_data(rd1_nb), .rs1_busy(b1_nb),
        .rd2_data(rd2_nb), .rs2_busy(b2_nb),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        rs1_addr = '0; rs2_addr = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #2;

        // Every address reads zero and not busy while in reset.
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
            #1;
            check($sformatf("rst_rd1_x%0d", a), rd1_byp, 32'h0);
            check($sformatf("rst_rd2_x%0d", 31 - a), rd2_byp, 32'h0);
            check($sformatf("rst_b1_x%0d", a), {31'b0, b1_byp}, 32'h0);
            check($sformatf("rst_b2nb_x%0d", a), {31'b0, b2_nb}, 32'h0);
        end

        @(negedge clk) resetn = 1'b1;
        repeat (3) tick();

        // Writes and issues to x0 are dropped.
        rs1_addr = 5'd0;
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        check("x0_rd_same", rd1_byp, 32'h0);
        check("x0_busy_same", {31'b0, b1_byp}, 32'h0);
        tick(); idle_inputs(); #1;
        check("x0_rd_next", rd1_byp, 32'h0);
        check("x0_rd_next_nb", rd1_nb, 32'h0);
        check("x0_busy_next", {31'b0, b1_byp}, 32'h0);

        // Bypass vs. stored-only read of x7.
        rs1_addr = 5'd7;
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1234_5678;
        #1;
        check("x7_bypass", rd1_byp, 32'h1234_5678);
        check("x7_nobypass_old", rd1_nb, 32'h0);
        tick(); idle_inputs(); #1;
        check("x7_stored", rd1_byp, 32'h1234_5678);
        check("x7_stored_nb", rd1_nb, 32'h1234_5678);

        // Collision on x9: port B data wins in storage and in bypass.
        rs1_addr = 5'd9; rs2_addr = 5'd9;
        wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'hAAAA_0000;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h5555_0000;
        #1;
        check("x9_coll_byp1", rd1_byp, 32'h5555_0000);
        check("x9_coll_byp2", rd2_byp, 32'h5555_0000);
        check("x9_coll_nb", rd1_nb, 32'h0);
        tick(); idle_inputs(); #1;
        check("x9_stored", rd1_byp, 32'h5555_0000);
        check("x9_stored_nb", rd2_nb, 32'h5555_0000);

        // Scoreboard on x3: re-issue in writeback cycle keeps it busy.
        rs2_addr = 5'd3;
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        check("x3_busy_issue_cycle", {31'b0, b2_byp}, 32'h0);
        tick(); idle_inputs(); #1;
        check("x3_busy", {31'b0, b2_byp}, 32'h1);
        check("x3_busy_nb", {31'b0, b2_nb}, 32'h1);
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h42;
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        check("x3_busy_masked_by_wb", {31'b0, b2_byp}, 32'h0);
        check("x3_fwd", rd2_byp, 32'h42);
        tick(); idle_inputs(); #1;
        check("x3_reissue_busy", {31'b0, b2_byp}, 32'h1);
        check("x3_data_nb", rd2_nb, 32'h42);
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h42;
        tick(); idle_inputs(); #1;
        check("x3_cleared", {31'b0, b2_byp}, 32'h0);
        check("x3_cleared_nb", {31'b0, b2_nb}, 32'h0);
        check("x3_data", rd2_byp, 32'h42);

        // Flush clears busy, ignores same-cycle issue, commits writes.
        issue_valid = 1'b1;
        issue_rd = 5'd4; tick();
        issue_rd = 5'd6; tick();
        issue_rd = 5'd8; tick();
        idle_inputs();
        rs1_addr = 5'd4; rs2_addr = 5'd6; #1;
        check("x4_busy", {31'b0, b1_byp}, 32'h1);
        check("x6_busy", {31'b0, b2_byp}, 32'h1);
        rs1_addr = 5'd8; #1;
        check("x8_busy", {31'b0, b1_nb}, 32'h1);
        flush = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd10;
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'hCAFE_0004;
        tick(); idle_inputs();
        rs1_addr = 5'd4; rs2_addr = 5'd10; #1;
        check("flush_x4_busy", {31'b0, b1_byp}, 32'h0);
        check("flush_x4_data", rd1_nb, 32'hCAFE_0004);
        check("flush_x10_busy", {31'b0, b2_byp}, 32'h0);
        rs1_addr = 5'd6; rs2_addr = 5'd8; #1;
        check("flush_x6_busy", {31'b0, b1_byp}, 32'h0);
        check("flush_x8_busy", {31'b0, b2_nb}, 32'h0);

        // Write to a register that was never issued: stored, stays not busy.
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_0077;
        tick(); idle_inputs();
        rs1_addr = 5'd12; #1;
        check("x12_data", rd1_nb, 32'h77);
        check("x12_busy", {31'b0, b1_byp}, 32'h0);

        // Mid-stream reset wipes state immediately and discards in-flight traffic.
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEAD_BEEF;
        issue_valid = 1'b1; issue_rd = 5'd13;
        tick(); idle_inputs();
        rs1_addr = 5'd5; rs2_addr = 5'd13; #1;
        check("x5_before_rst", rd1_byp, 32'hDEAD_BEEF);
        check("x13_busy_before_rst", {31'b0, b2_byp}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        check("x5_in_rst", rd1_byp, 32'h0);
        check("x5_in_rst_nb", rd1_nb, 32'h0);
        check("x13_busy_in_rst", {31'b0, b2_byp}, 32'h0);
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h0000_0001;
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        check("x5_bypass_in_rst", rd1_byp, 32'h0);
        tick(); idle_inputs();
        @(negedge clk) resetn = 1'b1;
        repeat (3) tick();
        rs1_addr = 5'd5; rs2_addr = 5'd9; #1;
        check("x5_after_rst", rd1_byp, 32'h0);
        check("x5_busy_after_rst", {31'b0, b1_byp}, 32'h0);
        check("x9_after_rst", rd2_nb, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_regfile_sb.md
Name: rv_regfile_sb

Overview:
Parametrised integer register file for the pipelined RV32I core.
- Two read ports and two write ports: port A for ALU writeback, port B for load return.
- Optional write-to-read bypass.
- Built-in scoreboard of pending destination registers. Decode uses it to detect RAW hazards; a pipeline flush clears it.

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of architectural registers (power of two, ≥2).
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see only stored values.
(AW = clog2(NREGS) is a derived localparam, not overridable.)

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
rs1_addr  in  AW  read port 1 address.
rs2_addr  in  AW  read port 2 address.
rd1_data  out  XLEN  read port 1 data (combinational).
rs1_busy  out  1  rs1 has a pending, unwritten producer (combinational).
rd2_data  out  XLEN  read port 2 data (combinational).
rs2_busy  out  1  rs2 has a pending, unwritten producer (combinational).
issue_valid  in  1  an instruction with a destination is issued this cycle.
issue_rd  in  AW  destination of the issued instruction.
wa_en  in  1  write port A enable.
wa_addr  in  AW  write port A address.
wa_data  in  XLEN  write port A data.
wb_en  in  1  write port B enable.
wb_addr  in  AW  write port B address.
wb_data  in  XLEN  write port B data.
flush  in  1  clear all scoreboard busy bits.

Behaviour:
- Reset (resetn=0, async): all registers = 0, all busy bits = 0.
  - Outputs are combinational, so during reset rd1_data/rd2_data = 0 and rs1_busy/rs2_busy = 0.
  - Deassertion is synchronous to clk in the top level.
- Register 0:
  - Reads always return 0.
  - Writes to address 0 are dropped.
  - Issue to address 0 never sets busy.
  - rsN_busy is always 0 for address 0.
- Writes commit on the rising edge. Write to read latency is 1 cycle with BYPASS=0 and 0 cycles with BYPASS=1.
- Write collision (wa_en & wb_en, same nonzero address): port B data is stored. One write occurs and busy clears once.
- Bypass (BYPASS=1): if rsN_addr≠0 matches an enabled write address this cycle, rdN_data = that write data, with port B priority over port A.
- Scoreboard, per-register busy bit, updated on the rising edge in this priority order:
  1. flush=1: all busy bits ← 0. Issue in the same cycle is ignored; writes still commit.
  2. issue_valid & issue_rd≠0: busy[issue_rd] ← 1. This wins over a same-cycle write to the same register (new producer).
  3. Enabled write to addr≠0: busy[addr] ← 0.
- Write to a non-busy register: allowed, data stored, busy unchanged (stays 0).
- rsN_busy:
  - BYPASS=1: busy[rsN_addr] & ~(a same-cycle write to rsN_addr).
  - BYPASS=0: busy[rsN_addr] & ~(a same-cycle write to rsN_addr), evaluated using the registered value only. The write's data is not forwarded in this mode; the consumer must re-read next cycle.
- Reset asserted mid-operation: in-flight writes and issues are discarded, and the state matches a fresh reset.
- No X propagation: address inputs are full-range decoded, so every index is valid.

Decomposition:
- Package rv_core_pkg: XLEN default, REG_ZERO constant (0), and reg_addr_t typedef sized from NREGS.
- Sub-module rf_scoreboard (NREGS-bit busy vector with issue/clear/flush logic and two busy lookups), instantiated once.
- Storage array, write-priority mux and bypass mux live in the top module.

Test Plan:
- Reset, then read all 32 addresses → every rd1_data/rd2_data = 0 and every busy = 0. Assert resetn mid-stream after writing x5=0xDEAD_BEEF → x5 reads 0 immediately.
- wa_en, wa_addr=0, wa_data=0xFFFF_FFFF; issue_rd=0 → rd1_data for rs1=0 stays 0, rs1_busy stays 0.
- BYPASS=1: wa writes x7=0x1234_5678 while rs1_addr=7 → rd1_data=0x1234_5678 in the same cycle. BYPASS=0: the old value is read that cycle and the new value the next cycle.
- wa and wb both write x9 (0xAAAA_0000 / 0x5555_0000) → x9 = 0x5555_0000, and the same-cycle bypass also shows 0x5555_0000.
- Issue x3 → next cycle rs2_busy=1 for rs2=3. Writeback x3=0x42 while issuing x3 again → busy stays 1. Writeback x3 without a new issue → busy=0 and data=0x42.
- Issue x4, x6, x8 → busy set. Then flush=1 with issue x10 in the same cycle → all busy=0, including x10. A port-A write to x4 in the flush cycle still commits.
